// File: rtl/synth_pkg.sv
// Shared types and helpers for the voice engine and related audio blocks.
package synth_pkg;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'b00,
    WAVE_SAW    = 2'b01,
    WAVE_TRI    = 2'b10,
    WAVE_MUTE   = 2'b11
  } wave_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    OUT
  } eng_state_t;

  // Clamp x to the signed range of a w-bit value; caller keeps the low w bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/synth_wave_gen.sv
// Combinational waveform generator: phase accumulator value and shape select to a raw sample.
module synth_wave_gen
  import synth_pkg::*;
#(
  parameter int unsigned PHASE_W  = 24,
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic        [PHASE_W-1:0]  phase,
  input  wave_t                      wave_sel,
  output logic signed [SAMPLE_W-1:0] raw
);

  localparam logic [SAMPLE_W-1:0]        HALF     = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic signed [SAMPLE_W-1:0] POS_FULL = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W-1:0] NEG_FULL = -POS_FULL;

  logic [SAMPLE_W-1:0] p;
  logic [SAMPLE_W-2:0] q;

  assign p = phase[PHASE_W-1 -: SAMPLE_W];

  // Sub-sample phase bits only matter for accumulation, not for the shape.
  generate
    if (PHASE_W > SAMPLE_W) begin : g_low_bits
      logic unused_phase_lsbs;
      assign unused_phase_lsbs = ^phase[PHASE_W-SAMPLE_W-1:0];
    end
  endgenerate

  always_comb begin
    raw = '0;
    q   = p[SAMPLE_W-1] ? ~p[SAMPLE_W-2:0] : p[SAMPLE_W-2:0];
    case (wave_sel)
      WAVE_SQUARE: raw = p[SAMPLE_W-1] ? NEG_FULL : POS_FULL;
      WAVE_SAW:    raw = p - HALF;
      WAVE_TRI:    raw = {q, 1'b0} - HALF;
      default:     raw = '0;
    endcase
  end

endmodule

// File: rtl/synth_voice_engine.sv
// Time-multiplexed N-voice oscillator core: one shared wave/MAC datapath, one mixed
// saturated sample per accepted sample_tick.
module synth_voice_engine
  import synth_pkg::*;
#(
  parameter int unsigned N_VOICES  = 8,
  parameter int unsigned SAMPLE_W  = 16,
  parameter int unsigned PHASE_W   = 24,
  parameter int unsigned VOL_W     = 8,
  parameter int unsigned OUT_SHIFT = 0
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                enable,
  input  logic                                sample_tick,
  input  logic [N_VOICES-1:0][PHASE_W-1:0]    phase_inc,
  input  logic [N_VOICES-1:0][1:0]            wave_sel,
  input  logic [N_VOICES-1:0][VOL_W-1:0]      volume,
  input  logic                                overrun_clr,
  output logic signed [SAMPLE_W-1:0]          out_sample,
  output logic                                out_valid,
  output logic                                busy,
  output logic                                overrun
);

  localparam int unsigned ACC_W  = SAMPLE_W + $clog2(N_VOICES) + 1;
  localparam int unsigned IDX_W  = $clog2(N_VOICES);
  localparam int unsigned PROD_W = SAMPLE_W + VOL_W + 1;

  eng_state_t state, state_next;

  logic                                tick_ok;
  logic                                start;
  logic                                last_voice;
  logic [IDX_W-1:0]                    idx;
  logic [N_VOICES-1:0][PHASE_W-1:0]    phase;
  logic [PHASE_W-1:0]                  cur_phase;
  wave_t                               cur_wave;
  logic signed [SAMPLE_W-1:0]          raw;
  logic signed [SAMPLE_W-1:0]          s2_raw;
  logic [VOL_W-1:0]                    s2_vol;
  logic                                s2_valid;
  logic signed [PROD_W-1:0]            prod_full;
  logic signed [PROD_W-1:0]            prod_shift;
  logic signed [ACC_W-1:0]             acc;
  logic signed [ACC_W-1:0]             acc_sum;

  assign tick_ok    = enable & sample_tick;
  assign last_voice = (idx == IDX_W'(N_VOICES - 1));
  assign cur_phase  = phase[idx];
  assign cur_wave   = wave_t'(wave_sel[idx]);

  synth_wave_gen #(
    .PHASE_W  (PHASE_W),
    .SAMPLE_W (SAMPLE_W)
  ) u_wave (
    .phase    (cur_phase),
    .wave_sel (cur_wave),
    .raw      (raw)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (tick_ok) begin
          state_next = RUN;
          start      = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_voice) state_next = DRAIN;
      end
      DRAIN: begin
        busy       = 1'b1;
        state_next = OUT;
      end
      OUT: begin
        if (tick_ok) begin
          state_next = RUN;
          start      = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Floor-scaled product always fits SAMPLE_W bits, so the narrowing cast is exact.
  always_comb begin
    prod_full  = PROD_W'(s2_raw) * PROD_W'($signed({1'b0, s2_vol}));
    prod_shift = prod_full >>> VOL_W;
    acc_sum    = acc + ACC_W'(prod_shift);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx      <= '0;
      phase    <= '0;
      s2_raw   <= '0;
      s2_vol   <= '0;
      s2_valid <= 1'b0;
      acc      <= '0;
    end else begin
      s2_valid <= (state == RUN);
      if (state == RUN) begin
        phase[idx] <= phase[idx] + phase_inc[idx];
        s2_raw     <= raw;
        s2_vol     <= volume[idx];
        idx        <= idx + IDX_W'(1);
      end
      if (start) begin
        idx <= '0;
        acc <= '0;
      end else if (s2_valid) begin
        acc <= acc_sum;
      end
    end
  end

  // The last product is folded in combinationally on the DRAIN edge so the result
  // is already on out_sample while the FSM sits in OUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_sample <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= (state == DRAIN);
      if (state == DRAIN)
        out_sample <= SAMPLE_W'(saturate(acc_sum >>> OUT_SHIFT, SAMPLE_W));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              overrun <= 1'b0;
    else if (tick_ok && busy)  overrun <= 1'b1;
    else if (overrun_clr)      overrun <= 1'b0;
  end

endmodule

// File: tb/tb_synth_voice_engine.sv
// Scoreboard bench for synth_voice_engine with a cycle-level reference model.
module tb_synth_voice_engine;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b1;
  logic                    enable = 1'b1;
  logic                    sample_tick = 1'b0;
  logic                    overrun_clr = 1'b0;
  logic [7:0][23:0]        phase_inc;
  logic [7:0][1:0]         wave_sel;
  logic [7:0][7:0]         volume;
  logic signed [15:0]      out_sample;
  logic                    out_valid;
  logic                    busy;
  logic                    overrun;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_t = -100;
  bit          m_ovr = 1'b0;
  int unsigned m_phase[8];
  int          exp_val_q[$];
  int          exp_cyc_q[$];

  synth_voice_engine #(
    .N_VOICES  (8),
    .SAMPLE_W  (16),
    .PHASE_W   (24),
    .VOL_W     (8),
    .OUT_SHIFT (0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .sample_tick (sample_tick),
    .phase_inc   (phase_inc),
    .wave_sel    (wave_sel),
    .volume      (volume),
    .overrun_clr (overrun_clr),
    .out_sample  (out_sample),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  function automatic int model_frame();
    int acc;
    acc = 0;
    for (int v = 0; v < 8; v++) begin
      int p, q, raw, g;
      p = int'(m_phase[v] >> 8);
      case (wave_sel[v])
        2'b00:   raw = (p < 32768) ? 32767 : -32767;
        2'b01:   raw = p - 32768;
        2'b10: begin
          q   = (p >= 32768) ? (65535 - p) : p;
          raw = 2 * q - 32768;
        end
        default: raw = 0;
      endcase
      g   = int'(volume[v]);
      acc = acc + ((raw * g) >>> 8);
      m_phase[v] = (m_phase[v] + int'(phase_inc[v])) & 32'h00FF_FFFF;
    end
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  task automatic cycle(input bit tick);
    bit busy_now;
    bit exp_busy;
    int val;
    int due;
    busy_now    = (cyc >= last_t + 1) && (cyc <= last_t + 9);
    sample_tick = tick;
    if (tick && enable && !busy_now) begin
      exp_val_q.push_back(model_frame());
      exp_cyc_q.push_back(cyc + 10);
      last_t = cyc;
    end
    if (tick && enable && busy_now) m_ovr = 1'b1;
    else if (overrun_clr)           m_ovr = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    sample_tick = 1'b0;
    overrun_clr = 1'b0;
    exp_busy = (cyc >= last_t + 1) && (cyc <= last_t + 9);
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL busy @%0d: got %b expected %b", cyc, busy, exp_busy);
    end
    checks++;
    if (overrun !== m_ovr) begin
      errors++;
      $display("FAIL overrun @%0d: got %b expected %b", cyc, overrun, m_ovr);
    end
    if (out_valid === 1'b1) begin
      checks++;
      if (exp_val_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid @%0d: got out_valid 1 expected 0", cyc);
      end else begin
        val = exp_val_q.pop_front();
        due = exp_cyc_q.pop_front();
        if (out_sample !== val) begin
          errors++;
          $display("FAIL out_sample @%0d: got %0d expected %0d", cyc, out_sample, val);
        end
        checks++;
        if (cyc != due) begin
          errors++;
          $display("FAIL latency: out_valid at cycle %0d expected %0d", cyc, due);
        end
      end
    end else if (exp_cyc_q.size() != 0 && exp_cyc_q[0] <= cyc) begin
      checks++;
      errors++;
      val = exp_val_q.pop_front();
      due = exp_cyc_q.pop_front();
      $display("FAIL missing_valid @%0d: got out_valid %b expected 1 (value %0d due %0d)",
               cyc, out_valid, val, due);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  task automatic set_all(input logic [1:0] sel, input logic [7:0] vol, input logic [23:0] inc);
    for (int v = 0; v < 8; v++) begin
      wave_sel[v]  = sel;
      volume[v]    = vol;
      phase_inc[v] = inc;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    checks++;
    if (out_sample !== 16'sd0) begin
      errors++;
      $display("FAIL reset_out_sample: got %0d expected 0", out_sample);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_overrun: got %b expected 0", overrun);
    end
    @(posedge clk);
    #1;
    cyc++;
    reset_n = 1'b1;
    exp_val_q.delete();
    exp_cyc_q.delete();
    for (int v = 0; v < 8; v++) m_phase[v] = 0;
    last_t = -100;
    m_ovr  = 1'b0;
  endtask

  task automatic test_reset();
    set_all(2'b11, 8'd0, 24'd0);
    do_reset();
    idle(3);
  endtask

  task automatic test_square();
    set_all(2'b11, 8'd255, 24'd0);
    wave_sel[0]  = 2'b00;
    phase_inc[0] = 24'h80_0000;
    cycle(1'b1);
    idle(12);
    cycle(1'b1);
    idle(12);
  endtask

  task automatic test_saw_frozen();
    do_reset();
    set_all(2'b11, 8'd255, 24'd0);
    wave_sel[0] = 2'b01;
    cycle(1'b1);
    idle(12);
    cycle(1'b1);
    idle(12);
  endtask

  task automatic test_saturate();
    do_reset();
    set_all(2'b00, 8'd255, 24'h80_0000);
    cycle(1'b1);
    idle(12);
    cycle(1'b1);
    idle(12);
  endtask

  task automatic test_overrun();
    set_all(2'b11, 8'd200, 24'h01_2345);
    wave_sel[2] = 2'b01;
    cycle(1'b1);
    idle(3);
    cycle(1'b1);
    overrun_clr = 1'b1;
    cycle(1'b1);
    overrun_clr = 1'b1;
    cycle(1'b0);
    idle(3);
    cycle(1'b1);
    idle(12);
  endtask

  task automatic test_enable();
    set_all(2'b10, 8'd90, 24'h03_1000);
    cycle(1'b1);
    idle(2);
    enable = 1'b0;
    idle(2);
    cycle(1'b1);
    idle(8);
    cycle(1'b1);
    idle(12);
    enable = 1'b1;
  endtask

  task automatic test_reset_midframe();
    set_all(2'b01, 8'd128, 24'h12_3456);
    cycle(1'b1);
    idle(4);
    do_reset();
    idle(12);
    cycle(1'b1);
    idle(12);
  endtask

  task automatic test_tri_wrap();
    do_reset();
    set_all(2'b11, 8'd255, 24'd0);
    wave_sel[0]  = 2'b10;
    phase_inc[0] = 24'h40_0000;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1);
      idle(10);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      for (int v = 0; v < 8; v++) begin
        wave_sel[v]  = 2'($urandom_range(0, 3));
        volume[v]    = 8'($urandom_range(0, 255));
        phase_inc[v] = 24'($urandom);
      end
      cycle(1'b1);
      idle(9);
    end
    idle(12);
  endtask

  initial begin
    set_all(2'b11, 8'd0, 24'd0);
    #1;
    test_reset();
    test_square();
    test_saw_frozen();
    test_saturate();
    test_overrun();
    test_enable();
    test_reset_midframe();
    test_tri_wrap();
    test_back_to_back();
    if (exp_val_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending outputs expected 0", exp_val_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
